// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_pkg
//  Description : Shared definitions for the instruction/data memory port
//                arbiter. Holds the FSM state encodings, the default watchdog
//                limit and the helper that sizes the watchdog counter.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    // FSM state encodings
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_BUSY_I = 2'd1;
    localparam logic [1:0] c_BUSY_D = 2'd2;

    // Default busy-cycle limit before an access is aborted (0 disables)
    localparam int c_DEF_TIMEOUT = 16;

    // Watchdog counter width: wide enough to hold TIMEOUT, never below 1 bit
    function automatic int wd_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/arb_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : arb_watchdog
//  Description : Busy-cycle counter for the memory port arbiter. Counts the
//                edges on which i_enable is high and flags o_expired on the
//                edge that would bring the count to TIMEOUT, so the arbiter
//                can abort on that same edge.
//  Ports       : clk       - clock, rising edge
//                reset     - asynchronous active-low reset
//                i_clear   - synchronous clear (a new access is granted)
//                i_enable  - count this edge (busy and memory not ready)
//                o_expired - this edge completes TIMEOUT busy cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_watchdog
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = c_DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int c_W = wd_width(TIMEOUT);

    logic [c_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + c_W'(1);
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_disabled
            assign o_expired = 1'b0;
        end else begin : g_enabled
            // Expiry is decided on the edge that would make the count reach
            // TIMEOUT, i.e. while the stored count is still TIMEOUT-1.
            localparam logic [c_W-1:0] c_LAST = c_W'(TIMEOUT - 1);
            assign o_expired = i_enable && (r_count == c_LAST);
        end
    endgenerate

endmodule : arb_watchdog
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-ported unified memory between the CPU
//                instruction-fetch port and its load/store port. One access
//                at a time; the request is held on the memory bus until
//                mem_ready, then a one-cycle ack returns the read data. A
//                watchdog aborts accesses the memory never completes.
//  Ports       : clk, reset                     - clock / async active-low reset
//                i_req, i_addr                  - fetch request
//                i_ack, i_rdata                 - fetch ack pulse and instruction
//                d_req, d_addr, d_we, d_wdata   - load/store request
//                d_ack, d_rdata                 - data ack pulse and load data
//                err                            - pulses with an aborted ack
//                mem_req, mem_we, mem_addr,
//                mem_wdata                      - memory bus (registered)
//                mem_rdata, mem_ready           - memory response
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = c_DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    input  logic          d_we,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    logic [1:0]    r_state;
    logic          r_last_d;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_i_ack;
    logic          r_d_ack;
    logic          r_err;
    logic [DW-1:0] r_i_rdata;
    logic [DW-1:0] r_d_rdata;

    logic w_i_cand;
    logic w_d_cand;
    logic w_grant_i;
    logic w_grant_d;
    logic w_grant;
    logic w_busy;
    logic w_wd_enable;
    logic w_expired;

    // A requester in its ack cycle is still allowed to show req high for that
    // cycle; masking it prevents a spurious second access.
    assign w_i_cand = i_req && !r_i_ack;
    assign w_d_cand = d_req && !r_d_ack;

    // Data wins a tie unless it won the previous grant, so contending
    // requesters alternate.
    assign w_grant_d = (r_state == c_IDLE) && w_d_cand && (!w_i_cand || !r_last_d);
    assign w_grant_i = (r_state == c_IDLE) && w_i_cand && !w_grant_d;
    assign w_grant   = w_grant_i || w_grant_d;

    assign w_busy      = (r_state == c_BUSY_I) || (r_state == c_BUSY_D);
    assign w_wd_enable = w_busy && !mem_ready;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_grant),
        .i_enable  (w_wd_enable),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_IDLE;
            r_last_d    <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_err       <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
        end else begin
            // Acks and err are single-cycle pulses
            r_i_ack <= 1'b0;
            r_d_ack <= 1'b0;
            r_err   <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    if (w_grant_d) begin
                        r_state     <= c_BUSY_D;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= d_we;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                        r_last_d    <= 1'b1;
                    end else if (w_grant_i) begin
                        r_state     <= c_BUSY_I;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= i_addr;
                        r_mem_wdata <= '0;
                        r_last_d    <= 1'b0;
                    end
                end

                c_BUSY_I: begin
                    // mem_ready takes precedence over an expiry on the same edge
                    if (mem_ready) begin
                        r_state   <= c_IDLE;
                        r_mem_req <= 1'b0;
                        r_i_ack   <= 1'b1;
                        r_i_rdata <= mem_rdata;
                    end else if (w_expired) begin
                        r_state   <= c_IDLE;
                        r_mem_req <= 1'b0;
                        r_i_ack   <= 1'b1;
                        r_err     <= 1'b1;
                        r_i_rdata <= '0;
                    end
                end

                c_BUSY_D: begin
                    if (mem_ready) begin
                        r_state   <= c_IDLE;
                        r_mem_req <= 1'b0;
                        r_d_ack   <= 1'b1;
                        r_d_rdata <= r_mem_we ? '0 : mem_rdata;
                    end else if (w_expired) begin
                        r_state   <= c_IDLE;
                        r_mem_req <= 1'b0;
                        r_d_ack   <= 1'b1;
                        r_err     <= 1'b1;
                        r_d_rdata <= '0;
                    end
                end

                default: begin
                    r_state   <= c_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign i_ack     = r_i_ack;
    assign i_rdata   = r_i_rdata;
    assign d_ack     = r_d_ack;
    assign d_rdata   = r_d_rdata;
    assign err       = r_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule : mem_port_arbiter
`default_nettype wire
